// File: rtl/sha_1_arb_pkg.sv
// Shared types for the sha_1_arbiter slice.
//   arb_state_t : arbiter sequencer states
//   block_t     : one pre-padded 512-bit message block, word 0 at index 0
//   digest_t    : H0..H4, H0 at index 0
package sha_1_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StBusy,
    StResp
  } arb_state_t;

  typedef logic [15:0][31:0] block_t;
  typedef logic [4:0][31:0]  digest_t;

endpackage

// File: rtl/sha_1_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from rr_ptr_i, wrapping at N_REQ-1 -> 0, for the first asserted request.
//   req_i     : level request vector
//   rr_ptr_i  : index with highest priority this round (always < N_REQ)
//   any_req_o : at least one request is asserted
//   idx_o     : index of the selected requester (0 when any_req_o is low)
module sha_1_rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PtrW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PtrW-1:0]  rr_ptr_i,
  output logic             any_req_o,
  output logic [PtrW-1:0]  idx_o
);

  always_comb begin
    int unsigned k;
    k         = 0;
    any_req_o = 1'b0;
    idx_o     = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      // Explicit wrap: N_REQ need not be a power of two.
      k = 32'(rr_ptr_i) + off;
      if (k >= N_REQ) k = k - N_REQ;
      if (!any_req_o && req_i[k]) begin
        any_req_o = 1'b1;
        idx_o     = PtrW'(k);
      end
    end
  end

endmodule

// File: rtl/sha_1_arbiter.sv
// Round-robin arbiter/sequencer sharing one sha_1_core between N_REQ requesters.
// Accepts one block per grant, pulses core_enable once, waits for core_done, returns the
// digest to the owning requester and rotates priority.
// Optional watchdog: define SHA_1_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles
// with rsp_err=1 and a zero digest; without it rsp_err is tied to 0.
//   clk, reset_n    : clock, asynchronous active-low reset
//   req, req_block  : per-requester level request and block (stable while requesting)
//   gnt             : one-hot one-cycle pulse, block accepted
//   rsp_valid       : one-hot one-cycle pulse, rsp_digest/rsp_err belong to that requester
//   rsp_digest      : H0..H4, held until the next response
//   rsp_err         : timeout abort flag, valid with rsp_valid
//   busy            : arbiter not in IDLE
//   core_enable     : one-cycle start pulse to the core
//   core_data       : registered block driven to the core
//   core_result     : core digest, captured on core_done in BUSY
//   core_done       : core completion pulse (ignored outside BUSY)
module sha_1_arbiter
  import sha_1_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 127
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  block_t [N_REQ-1:0]   req_block,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output digest_t              rsp_digest,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 core_enable,
  output block_t               core_data,
  input  digest_t              core_result,
  input  logic                 core_done
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] OneHot0 = {{(N_REQ - 1){1'b0}}, 1'b1};

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("sha_1_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sha_1_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t        state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic              core_enable_q, core_enable_d;
  block_t            core_data_q, core_data_d;
  digest_t           rsp_digest_q, rsp_digest_d;
  logic              any_req;
  logic [PtrW-1:0]   pick_idx;
  logic              timeout;

  sha_1_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .idx_o     (pick_idx)
  );

`ifdef SHA_1_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           rsp_err_q, rsp_err_d;

  // Cleared while launching so the first BUSY cycle sees 0.
  always_comb begin
    wd_d = wd_q;
    if (state_q == StLaunch)    wd_d = '0;
    else if (state_q == StBusy) wd_d = wd_q + WdW'(1);
  end

  // Fires in the TIMEOUT_CYCLES-th BUSY cycle.
  assign timeout = (state_q == StBusy) && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StLaunch;
      StLaunch: state_d = StBusy;
      StBusy:   if (core_done || timeout) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic; all outputs are registered.
  always_comb begin
    gnt_d         = '0;
    rsp_valid_d   = '0;
    core_enable_d = 1'b0;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    core_data_d   = core_data_q;
    rsp_digest_d  = rsp_digest_q;
`ifdef SHA_1_ARB_TIMEOUT_EN
    rsp_err_d     = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d       = OneHot0 << pick_idx;
          core_data_d = req_block[pick_idx];
          owner_d     = pick_idx;
          rr_ptr_d    = (pick_idx == PtrW'(N_REQ - 1)) ? '0 : pick_idx + PtrW'(1);
        end
      end
      StLaunch: core_enable_d = 1'b1;
      StBusy: begin
        if (core_done) begin
          rsp_digest_d = core_result;
          rsp_valid_d  = OneHot0 << owner_q;
`ifdef SHA_1_ARB_TIMEOUT_EN
          rsp_err_d    = 1'b0;
`endif
        end else if (timeout) begin
          rsp_digest_d = '0;
          rsp_valid_d  = OneHot0 << owner_q;
`ifdef SHA_1_ARB_TIMEOUT_EN
          rsp_err_d    = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      core_enable_q <= 1'b0;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      core_data_q   <= '0;
      rsp_digest_q  <= '0;
    end else begin
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      core_enable_q <= core_enable_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      core_data_q   <= core_data_d;
      rsp_digest_q  <= rsp_digest_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign core_enable = core_enable_q;
  assign core_data   = core_data_q;
  assign rsp_digest  = rsp_digest_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sha_1_arbiter.sv
// Scoreboard bench for sha_1_arbiter with a behavioural stand-in for sha_1_core.
module tb_sha_1_arbiter;
  import sha_1_arb_pkg::*;

  localparam int unsigned N = 4;
`ifdef SHA_1_ARB_TIMEOUT_EN
  localparam int unsigned TO = 10;
`else
  localparam int unsigned TO = 127;
`endif
  localparam int unsigned CoreLat = 5;

  typedef struct packed {
    logic [2:0] idx;
    digest_t    dig;
    logic       err;
  } rsp_t;

  logic             clk;
  logic             reset_n;
  logic [N-1:0]     req;
  block_t [N-1:0]   req_block;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rsp_valid;
  digest_t          rsp_digest;
  logic             rsp_err;
  logic             busy;
  logic             core_enable;
  block_t           core_data;
  digest_t          core_res;
  logic             core_done;
  logic             core_done_m;
  logic             core_done_force;
  logic             core_model_en;

  int   n_vec = 0;
  int   n_err = 0;
  int   gnt_exp[$];
  rsp_t rsp_exp[$];
  block_t blk[N];

  sha_1_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_block   (req_block),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_digest  (rsp_digest),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .core_enable (core_enable),
    .core_data   (core_data),
    .core_result (core_res),
    .core_done   (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  function automatic block_t abc_blk();
    block_t b = '0;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    return b;
  endfunction

  function automatic block_t empty_blk();
    block_t b = '0;
    b[0] = 32'h80000000;
    return b;
  endfunction

  function automatic block_t pat_blk(input int i);
    block_t b;
    for (int j = 0; j < 16; j++) b[j] = 32'(i) * 32'h01000000 + 32'(j) * 32'h00010101 + 32'h11;
    return b;
  endfunction

  // Reference digests for the known SHA-1 vectors; anything else gets an arbitrary fold.
  function automatic digest_t digest_of(input block_t b);
    digest_t d;
    if (b == abc_blk()) begin
      d[0] = 32'ha9993e36; d[1] = 32'h4706816a; d[2] = 32'hba3e2571;
      d[3] = 32'h7850c26c; d[4] = 32'h9cd0d89d;
    end else if (b == empty_blk()) begin
      d[0] = 32'hda39a3ee; d[1] = 32'h5e6b4b0d; d[2] = 32'h3255bfef;
      d[3] = 32'h95601890; d[4] = 32'hafd80709;
    end else begin
      for (int k = 0; k < 5; k++) d[k] = b[k] ^ b[k + 5] ^ b[k + 10] ^ (32'h5a5a0000 | 32'(k));
    end
    return d;
  endfunction

  function automatic rsp_t mk(input int i);
    mk.idx = 3'(i);
    mk.dig = digest_of(blk[i]);
    mk.err = 1'b0;
  endfunction

  // Stand-in core: not reset by reset_n, so a launched operation always finishes.
  int     core_cnt = 0;
  logic   core_run = 1'b0;
  block_t core_blk;
  initial begin
    core_done_m = 1'b0;
    core_res    = '0;
  end
  always @(posedge clk) begin
    core_done_m <= 1'b0;
    if (core_enable && core_model_en) begin
      core_run <= 1'b1;
      core_cnt <= CoreLat;
      core_blk <= core_data;
    end else if (core_run) begin
      if (core_cnt == 1) begin
        core_run    <= 1'b0;
        core_done_m <= 1'b1;
        core_res    <= digest_of(core_blk);
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end
  assign core_done = core_done_m | core_done_force;

  // Output monitor / scoreboard, sampled on the falling edge.
  logic prev_gnt  = 1'b0;
  logic prev_done = 1'b0;
  int   gi;
  rsp_t e;
  always @(negedge clk) begin
    if (reset_n) begin
      if (gnt != '0) begin
        if (gnt_exp.size() == 0) check_eq("gnt_unexpected", gnt, 0);
        else begin
          gi = gnt_exp.pop_front();
          check_eq("gnt_idx", gnt, onehot(gi));
        end
      end
      if (prev_gnt || core_enable) check_eq("cen_follow", core_enable, prev_gnt);
      if (rsp_valid != '0) begin
        if (rsp_exp.size() == 0) check_eq("rsp_unexpected", rsp_valid, 0);
        else begin
          e = rsp_exp.pop_front();
          check_eq("rsp_route", rsp_valid, onehot(int'(e.idx)));
          check_eq("rsp_digest", rsp_digest, e.dig);
          check_eq("rsp_err", rsp_err, e.err);
          if (!e.err) check_eq("rsp_lat", prev_done, 1);
        end
      end
    end
    prev_gnt  <= reset_n && (gnt != '0);
    prev_done <= core_done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int max);
    int n = 0;
    while (gnt == '0 && n < max) begin
      step();
      n++;
    end
    check_eq("gnt_wait", (gnt != '0), 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || gnt_exp.size() != 0 || rsp_exp.size() != 0) && n < max) begin
      step();
      n++;
    end
    check_eq("idle_wait", {busy, 1'(gnt_exp.size() != 0), 1'(rsp_exp.size() != 0)}, 0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  int g, n;
  initial begin
    blk[0] = abc_blk();
    blk[1] = pat_blk(1);
    blk[2] = empty_blk();
    blk[3] = pat_blk(3);
    for (int i = 0; i < N; i++) req_block[i] = blk[i];
    req             = '0;
    core_done_force = 1'b0;
    core_model_en   = 1'b1;
    reset_n         = 1'b0;
    #1;
    // Reset state.
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cen", core_enable, 0);
    check_eq("rst_core_data", core_data, 0);
    check_eq("rst_digest", rsp_digest, 0);
    check_eq("rst_err", rsp_err, 0);
    step();
    reset_n = 1'b1;
    step();

    // Single request, "abc".
    gnt_exp.push_back(0);
    rsp_exp.push_back(mk(0));
    req = 4'b0001;
    step();
    check_eq("gnt_lat", gnt, 4'b0001);
    req = '0;
    step();
    check_eq("cen_lat", core_enable, 1);
    check_eq("core_data", core_data, blk[0]);
    wait_idle(50);

    // Round robin from a fresh pointer: 0,1,2,3,0.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      gnt_exp.push_back(i);
      rsp_exp.push_back(mk(i));
    end
    gnt_exp.push_back(0);
    rsp_exp.push_back(mk(0));
    g = 0;
    n = 0;
    req = 4'b1111;
    while (g < 5 && n < 200) begin
      step();
      n++;
      if (gnt != '0) g++;
    end
    req = '0;
    check_eq("rr_count", g, 5);
    wait_idle(100);

    // Withdraw and wrap: grant 2 moves the pointer to 3; req[3] pulses while busy.
    gnt_exp.push_back(2);
    rsp_exp.push_back(mk(2));
    req = 4'b0100;
    wait_gnt(10);
    req = '0;
    step();
    step();
    gnt_exp.push_back(1);
    rsp_exp.push_back(mk(1));
    req = 4'b1010;
    step();
    req = 4'b0010;
    wait_gnt(50);
    check_eq("wrap_gnt", gnt, 4'b0010);
    req = '0;
    wait_idle(50);

    // Spurious done in IDLE and LAUNCH.
    core_done_force = 1'b1;
    step();
    core_done_force = 1'b0;
    check_eq("spur_idle_busy", busy, 0);
    check_eq("spur_idle_rsp", rsp_valid, 0);
    gnt_exp.push_back(3);
    rsp_exp.push_back(mk(3));
    req = 4'b1000;
    wait_gnt(10);
    core_done_force = 1'b1;
    req = '0;
    step();
    core_done_force = 1'b0;
    check_eq("spur_launch_busy", busy, 1);
    step();
    check_eq("spur_launch_rsp", rsp_valid, 0);
    check_eq("spur_launch_busy2", busy, 1);
    wait_idle(50);

    // Reset mid-BUSY: no response, late core_done ignored, pointer back to 0.
    gnt_exp.push_back(2);
    req = 4'b0100;
    wait_gnt(10);
    req = '0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_gnt", gnt, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_cen", core_enable, 0);
    check_eq("mid_rst_core_data", core_data, 0);
    check_eq("mid_rst_digest", rsp_digest, 0);
    check_eq("mid_rst_rsp", rsp_valid, 0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_eq("late_done_busy", busy, 0);
    check_eq("late_done_digest", rsp_digest, 0);
    gnt_exp.push_back(1);
    rsp_exp.push_back(mk(1));
    req = 4'b1010;
    wait_gnt(10);
    req = '0;
    wait_idle(50);

`ifdef SHA_1_ARB_TIMEOUT_EN
    // Watchdog: core never finishes.
    core_model_en = 1'b0;
    gnt_exp.push_back(0);
    rsp_exp.push_back('{idx: 3'd0, dig: '0, err: 1'b1});
    req = 4'b0001;
    wait_gnt(10);
    req = '0;
    step();
    check_eq("to_cen", core_enable, 1);
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      step();
      n++;
    end
    check_eq("to_cycles", n, TO);
    check_eq("to_err", rsp_err, 1);
    step();
    check_eq("to_idle", busy, 0);
    wait_idle(20);
    core_model_en = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
